// File: rtl/famicom_pad_responder.sv
// Pad-side 4021-style PISO responder for the console joypad port, re-timed into CLK.
// Strobe loads the button snapshot; each nCUP rising edge shifts one bit out on nD0.
module famicom_pad_responder #(
  parameter int   NBITS       = 8,
  parameter logic FILL        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             OUT_0,
  input  logic             nCUP,
  input  logic [NBITS-1:0] BTN,
  output logic             nD0,
  output logic [4:0]       SHIFT_CNT,
  output logic             EXHAUSTED
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [4:0] CNT_MAX = 5'(NBITS);

  state_t                 r_state;
  logic [NBITS-1:0]       r_shreg;
  logic [SYNC_STAGES-1:0] r_strb_sync;
  logic [SYNC_STAGES-1:0] r_cup_sync;
  logic                   r_cup_prev;

  logic             w_strb;
  logic             w_rise;
  logic [NBITS-1:0] w_shifted;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_strb_sync <= '0;
      r_cup_sync  <= '1;
      r_cup_prev  <= 1'b1;
    end else begin
      r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], OUT_0};
      r_cup_sync  <= {r_cup_sync[SYNC_STAGES-2:0], nCUP};
      r_cup_prev  <= r_cup_sync[SYNC_STAGES-1];
    end
  end

  assign w_strb    = r_strb_sync[SYNC_STAGES-1];
  assign w_rise    = r_cup_sync[SYNC_STAGES-1] & ~r_cup_prev;
  // Shift register is stored active-low, so the fill shifted in is the inverted SER level
  assign w_shifted = {~FILL, r_shreg[NBITS-1:1]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_shreg   <= '1;
      nD0       <= 1'b1;
      SHIFT_CNT <= '0;
      EXHAUSTED <= 1'b0;
    end else if (w_strb) begin
      // Transparent load: tracks BTN every cycle, and any shift edge is swallowed
      r_state   <= LOAD;
      r_shreg   <= ~BTN;
      nD0       <= ~BTN[0];
      SHIFT_CNT <= '0;
      EXHAUSTED <= 1'b0;
    end else begin
      if (r_state == LOAD)
        r_state <= SHIFT;
      if (w_rise) begin
        r_shreg <= w_shifted;
        nD0     <= w_shifted[0];
        if (SHIFT_CNT != CNT_MAX)
          SHIFT_CNT <= SHIFT_CNT + 5'd1;
        if (SHIFT_CNT >= CNT_MAX - 5'd1) begin
          r_state   <= DONE;
          EXHAUSTED <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_famicom_pad_responder.sv
// Directed bench for famicom_pad_responder (NBITS=8, FILL=0, SYNC_STAGES=2).
module tb_famicom_pad_responder;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       OUT_0;
  logic       nCUP;
  logic [7:0] BTN;
  logic       nD0;
  logic [4:0] SHIFT_CNT;
  logic       EXHAUSTED;

  int n_chk = 0;
  int n_err = 0;

  famicom_pad_responder #(.NBITS(8), .FILL(1'b0), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .nRST(nRST), .OUT_0(OUT_0), .nCUP(nCUP), .BTN(BTN),
    .nD0(nD0), .SHIFT_CNT(SHIFT_CNT), .EXHAUSTED(EXHAUSTED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // nCUP low 4 cycles then high 4; nD0 sampled just before the rising edge
  task automatic cup_pulse(input string tag, input logic exp_d0, input logic do_chk);
    nCUP = 1'b0;
    cyc(4);
    if (do_chk) chk(tag, 32'(nD0), 32'(exp_d0));
    nCUP = 1'b1;
    cyc(4);
  endtask

  task automatic strobe(input logic [7:0] b);
    BTN = b; OUT_0 = 1'b1;
    cyc(4);
    OUT_0 = 1'b0;
    cyc(5);
  endtask

  initial begin
    logic [7:0] exp_bits;
    nRST = 1'b0; OUT_0 = 1'b1; nCUP = 1'b1; BTN = 8'hFF;
    cyc(3);
    chk("rst_nd0", 32'(nD0), 32'd1);
    chk("rst_cnt", 32'(SHIFT_CNT), 32'd0);
    chk("rst_exh", 32'(EXHAUSTED), 32'd0);
    nRST = 1'b1;
    cyc(1);
    chk("rel_nd0", 32'(nD0), 32'd1);

    // Basic read: A, Select, Right pressed
    strobe(8'b1000_0101);
    exp_bits = 8'b0111_1010;
    for (int i = 0; i < 8; i++) cup_pulse($sformatf("basic_b%0d", i), exp_bits[i], 1'b1);
    chk("basic_cnt", 32'(SHIFT_CNT), 32'd8);
    chk("basic_exh", 32'(EXHAUSTED), 32'd1);

    for (int i = 0; i < 4; i++) cup_pulse($sformatf("exh_b%0d", i), 1'b1, 1'b1);
    chk("exh_cnt", 32'(SHIFT_CNT), 32'd8);

    // Live load and strobe latency: effect lands on the 3rd edge
    BTN = 8'h01; OUT_0 = 1'b1;
    cyc(2);
    chk("lat_nd0_pre", 32'(nD0), 32'd1);
    chk("lat_exh_pre", 32'(EXHAUSTED), 32'd1);
    cyc(1);
    chk("lat_nd0", 32'(nD0), 32'd0);
    chk("lat_cnt", 32'(SHIFT_CNT), 32'd0);
    chk("lat_exh", 32'(EXHAUSTED), 32'd0);
    BTN = 8'h00; cyc(4);
    chk("live_0", 32'(nD0), 32'd1);
    BTN = 8'h01; cyc(4);
    chk("live_1", 32'(nD0), 32'd0);
    cup_pulse("live_cup0", 1'b0, 1'b0);
    cup_pulse("live_cup1", 1'b0, 1'b0);
    chk("live_cnt", 32'(SHIFT_CNT), 32'd0);
    chk("live_nd0", 32'(nD0), 32'd0);

    // Snapshot hold: B captured, later BTN change ignored
    BTN = 8'h02; cyc(4);
    OUT_0 = 1'b0; cyc(5);
    BTN = 8'hFD;
    exp_bits = 8'b1111_1101;
    for (int i = 0; i < 8; i++) cup_pulse($sformatf("snap_b%0d", i), exp_bits[i], 1'b1);
    chk("snap_exh", 32'(EXHAUSTED), 32'd1);

    // Mid-frame re-strobe with a single-cycle OUT_0 pulse
    BTN = 8'hA5; OUT_0 = 1'b1; cyc(1); OUT_0 = 1'b0; cyc(6);
    chk("pulse_nd0", 32'(nD0), 32'd0);
    for (int i = 0; i < 3; i++) cup_pulse("mid_sh", 1'b0, 1'b0);
    chk("mid_cnt3", 32'(SHIFT_CNT), 32'd3);
    chk("mid_nd0_3", 32'(nD0), 32'd1);
    OUT_0 = 1'b1; cyc(1); OUT_0 = 1'b0; cyc(6);
    chk("restrobe_cnt", 32'(SHIFT_CNT), 32'd0);
    chk("restrobe_nd0", 32'(nD0), 32'd0);
    for (int i = 0; i < 5; i++) cup_pulse("mid_sh5", 1'b0, 1'b0);
    chk("mid_cnt5", 32'(SHIFT_CNT), 32'd5);
    chk("mid_nd0_5", 32'(nD0), 32'd0);

    // Asynchronous reset mid-frame
    nRST = 1'b0; #1;
    chk("arst_nd0", 32'(nD0), 32'd1);
    chk("arst_cnt", 32'(SHIFT_CNT), 32'd0);
    chk("arst_exh", 32'(EXHAUSTED), 32'd0);
    cyc(1);
    nRST = 1'b1; cyc(3);
    chk("post_rst_nd0", 32'(nD0), 32'd1);
    chk("post_rst_cnt", 32'(SHIFT_CNT), 32'd0);
    // Idle shifts like SHIFT, pushing ones out of the reset register
    cup_pulse("idle_sh", 1'b1, 1'b1);
    chk("idle_cnt", 32'(SHIFT_CNT), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
